// File: rtl/bsg_front_side_bus_hop_out_multi.sv
// Output stage of a front side bus hop: merges upstream (port 0) and N local ports into an els_p FIFO.
// Optional stall counter: define BSG_FSB_HOP_OUT_MULTI_STALL_CNT_EN.
module bsg_front_side_bus_hop_out_multi #(
  parameter int width_p       = 8,
  parameter int local_ports_p = 1,
  parameter int els_p         = 2
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [local_ports_p:0]             v_i,
  input  logic [(1+local_ports_p)*width_p-1:0] data_i,
  output logic                               ready_and_o,
  output logic [local_ports_p-1:0]           yumi_o,
  output logic                               v_o,
  output logic [width_p-1:0]                 data_o,
  input  logic                               ready_and_i,
  output logic [31:0]                        stall_cnt_o
);

  localparam int ptr_w_lp = (local_ports_p > 1) ? $clog2(local_ports_p) : 1;
  localparam int aw_lp    = $clog2(els_p);
  localparam int cw_lp    = $clog2(els_p + 1);
  localparam logic [cw_lp-1:0]    full_cnt_lp  = cw_lp'(els_p);
  localparam logic [aw_lp-1:0]    last_addr_lp = aw_lp'(els_p - 1);
  localparam logic [ptr_w_lp-1:0] last_port_lp = ptr_w_lp'(local_ports_p - 1);

  function automatic logic [aw_lp-1:0] addr_inc(input logic [aw_lp-1:0] a);
    return (a == last_addr_lp) ? {aw_lp{1'b0}} : a + aw_lp'(1);
  endfunction

  logic [width_p-1:0]       mem_r [els_p];
  logic [aw_lp-1:0]         wr_ptr_r, rd_ptr_r;
  logic [cw_lp-1:0]         count_r;
  logic                     blocked_r;
  logic [ptr_w_lp-1:0]      rr_ptr_r;

  logic [local_ports_p-1:0] v_local_s, onehot_s;
  logic                     space_s, deq_s, enq_s, up_xfer_s, local_ok_s, found_s, grant_s;
  logic [ptr_w_lp-1:0]      winner_s, rr_next_s;
  logic [width_p-1:0]       local_data_s, enq_data_s;
  int                       dist_s, best_s;

  assign v_local_s   = v_i[local_ports_p:1];
  assign v_o         = (count_r != {cw_lp{1'b0}});
  assign data_o      = mem_r[rd_ptr_r];
  assign deq_s       = v_o & ready_and_i;
  assign space_s     = (count_r != full_cnt_lp) | deq_s;
  assign ready_and_o = ~reset_i & space_s & ~blocked_r;
  assign up_xfer_s   = v_i[0] & ready_and_o;
  assign local_ok_s  = ~reset_i & space_s & (~v_i[0] | blocked_r);
  assign found_s     = |v_local_s;
  assign grant_s     = local_ok_s & found_s;
  assign yumi_o      = grant_s ? onehot_s : {local_ports_p{1'b0}};
  assign enq_s       = up_xfer_s | grant_s;
  assign enq_data_s  = up_xfer_s ? data_i[width_p-1:0] : local_data_s;
  assign rr_next_s   = (winner_s == last_port_lp) ? {ptr_w_lp{1'b0}} : winner_s + ptr_w_lp'(1);

  // Round-robin pick: valid local port with the smallest rotated distance from rr_ptr_r
  always_comb begin
    best_s       = local_ports_p;
    dist_s       = 0;
    winner_s     = rr_ptr_r;
    onehot_s     = {local_ports_p{1'b0}};
    local_data_s = data_i[width_p +: width_p];
    for (int j = 0; j < local_ports_p; j++) begin
      dist_s = j - int'(rr_ptr_r);
      if (dist_s < 0) begin
        dist_s = dist_s + local_ports_p;
      end else begin
        dist_s = dist_s;
      end
      if (v_local_s[j] && (dist_s < best_s)) begin
        best_s       = dist_s;
        winner_s     = ptr_w_lp'(j);
        onehot_s     = {local_ports_p{1'b0}};
        onehot_s[j]  = 1'b1;
        local_data_s = data_i[(j+1)*width_p +: width_p];
      end else begin
        best_s = best_s;
      end
    end
  end

  // Payload storage; contents are don't-care while v_o is low
  always_ff @(posedge clk_i) begin
    if (enq_s) mem_r[wr_ptr_r] <= enq_data_s;
  end

  // FIFO pointers/occupancy plus arbitration state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r  <= {aw_lp{1'b0}};
      rd_ptr_r  <= {aw_lp{1'b0}};
      count_r   <= {cw_lp{1'b0}};
      blocked_r <= 1'b0;
      rr_ptr_r  <= {ptr_w_lp{1'b0}};
    end else begin
      if (enq_s) wr_ptr_r <= addr_inc(wr_ptr_r);
      if (deq_s) rd_ptr_r <= addr_inc(rd_ptr_r);
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + cw_lp'(1);
        2'b01:   count_r <= count_r - cw_lp'(1);
        default: count_r <= count_r;
      endcase
      // A local loser reserves the next slot, giving up/local alternation
      if (space_s) blocked_r <= found_s & ~local_ok_s;
      if (grant_s) rr_ptr_r <= rr_next_s;
    end
  end

`ifdef BSG_FSB_HOP_OUT_MULTI_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles where the next switch holds off a valid word
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cnt_r <= 32'h0;
    end else if (v_o & ~ready_and_i & (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`else
  assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out_multi.sv
// Randomized and directed bench for bsg_front_side_bus_hop_out_multi against a queue-based reference model.
module tb_bsg_front_side_bus_hop_out_multi;
  localparam int W = 8;
  localparam int N = 2;
  localparam int ELS = 4;
`ifdef BSG_FSB_HOP_OUT_MULTI_STALL_CNT_EN
  localparam logic [31:0] STALL10 = 32'd10;
`else
  localparam logic [31:0] STALL10 = 32'd0;
`endif

  logic               clk_i = 1'b0;
  logic               reset_i = 1'b1;
  logic [N:0]         v_i = '0;
  logic [(N+1)*W-1:0] data_i = '0;
  logic               ready_and_o;
  logic [N-1:0]       yumi_o;
  logic               v_o;
  logic [W-1:0]       data_o;
  logic               ready_and_i = 1'b0;
  logic [31:0]        stall_cnt_o;

  always #5 clk_i = ~clk_i;

  bsg_front_side_bus_hop_out_multi #(.width_p(W), .local_ports_p(N), .els_p(ELS)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
    .ready_and_o(ready_and_o), .yumi_o(yumi_o), .v_o(v_o), .data_o(data_o),
    .ready_and_i(ready_and_i), .stall_cnt_o(stall_cnt_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [W-1:0] q[$];
  bit           blocked_m;
  int           rr_m;
  logic [31:0]  stall_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // one cycle: called at a negedge, returns at the next negedge
  task automatic step(input logic [N:0] v, input logic [(N+1)*W-1:0] d, input logic rdy);
    bit ev, deq, space, rdy_e, lok, found, up, grant;
    int win;
    logic [N-1:0] ey;
    v_i = v; data_i = d; ready_and_i = rdy;
    #1;
    ev    = (q.size() > 0);
    deq   = ev && rdy;
    space = (q.size() < ELS) || deq;
    rdy_e = space && !blocked_m;
    lok   = space && (!v[0] || blocked_m);
    found = 1'b0;
    win   = 0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (rr_m + i) % N;
      if (!found && v[k+1]) begin
        found = 1'b1;
        win   = k;
      end
    end
    up    = v[0] && rdy_e;
    grant = lok && found;
    ey    = '0;
    if (grant) ey[win] = 1'b1;
    chk("v_o", 32'(v_o), 32'(ev));
    chk("ready_and_o", 32'(ready_and_o), 32'(rdy_e));
    chk("yumi_o", 32'(yumi_o), 32'(ey));
    if (ev) chk("data_o", 32'(data_o), 32'(q[0]));
    chk("stall_cnt_o", stall_cnt_o, stall_m);
    @(posedge clk_i);
    if (deq) void'(q.pop_front());
    if (up) q.push_back(d[W-1:0]);
    else if (grant) q.push_back(d[(win+1)*W +: W]);
    if (space) blocked_m = (v[N:1] != '0) && !lok;
    if (grant) rr_m = (win + 1) % N;
`ifdef BSG_FSB_HOP_OUT_MULTI_STALL_CNT_EN
    if (ev && !rdy && stall_m != 32'hFFFF_FFFF) stall_m++;
`endif
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    v_i = '1;
    #1;
    chk("rst_v_o", 32'(v_o), 32'd0);
    chk("rst_ready", 32'(ready_and_o), 32'd0);
    chk("rst_yumi", 32'(yumi_o), 32'd0);
    chk("rst_stall", stall_cnt_o, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    v_i = '0;
    reset_i = 1'b0;
    q.delete();
    blocked_m = 1'b0;
    rr_m = 0;
    stall_m = 32'd0;
  endtask

  initial begin
    logic [N-1:0] pat [4];
    pat[0] = 2'b00; pat[1] = 2'b01; pat[2] = 2'b00; pat[3] = 2'b10;
    @(negedge clk_i);
    do_reset();

    // single upstream word appears one cycle later
    step(3'b001, 24'h00005A, 1'b1);
    chk("t1_data", 32'(data_o), 32'h5A);
    chk("t1_v", 32'(v_o), 32'd1);
    step(3'b000, 24'h0, 1'b1);

    // saturation: up, L1, up, L2 ...
    do_reset();
    for (int c = 0; c < 12; c++) begin
      v_i = 3'b111;
      ready_and_i = 1'b1;
      data_i = {8'hC0 + 8'(c), 8'hB0 + 8'(c), 8'hA0 + 8'(c)};
      #1;
      chk("t2_yumi", 32'(yumi_o), 32'(pat[c%4]));
      step(3'b111, {8'hC0 + 8'(c), 8'hB0 + 8'(c), 8'hA0 + 8'(c)}, 1'b1);
    end
    for (int c = 0; c < 4; c++) step(3'b000, 24'h0, 1'b1);

    // fill to depth, fifth word waits for drain
    do_reset();
    for (int c = 0; c < 4; c++) step(3'b001, 24'(c + 1), 1'b0);
    v_i = 3'b001; data_i = 24'd5; ready_and_i = 1'b0;
    #1;
    chk("t3_full_ready", 32'(ready_and_o), 32'd0);
    step(3'b001, 24'd5, 1'b0);
    step(3'b001, 24'd5, 1'b1);
    for (int c = 0; c < 6; c++) step(3'b000, 24'h0, 1'b1);

    // full FIFO with simultaneous dequeue and local enqueue
    do_reset();
    for (int c = 0; c < 4; c++) step(3'b001, 24'(8'h10 + c), 1'b0);
    v_i = 3'b010; data_i = 24'h007700; ready_and_i = 1'b1;
    #1;
    chk("t4_yumi", 32'(yumi_o), 32'd1);
    step(3'b010, 24'h007700, 1'b1);
    step(3'b000, 24'h0, 1'b0);
    for (int c = 0; c < 6; c++) step(3'b000, 24'h0, 1'b1);

    // asynchronous reset with words buffered
    do_reset();
    for (int c = 0; c < 3; c++) step(3'b001, 24'(8'h20 + c), 1'b0);
    #3;
    reset_i = 1'b1;
    #1;
    chk("t5_v_async", 32'(v_o), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    q.delete(); blocked_m = 1'b0; rr_m = 0; stall_m = 32'd0;
    step(3'b000, 24'h0, 1'b0);
    step(3'b000, 24'h0, 1'b1);
    chk("t5_v_after", 32'(v_o), 32'd0);

    // stall counter
    do_reset();
    step(3'b001, 24'h000033, 1'b0);
    for (int c = 0; c < 10; c++) step(3'b000, 24'h0, 1'b0);
    #1;
    chk("t6_stall", stall_cnt_o, STALL10);
    step(3'b000, 24'h0, 1'b1);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step(3'($urandom_range(0, 7)), 24'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int c = 0; c < 8; c++) step(3'b000, 24'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
